embnew16k_mem_loader: RTL and testbench
=======================================

// Module: embnew16k_mem_loader
// PURPOSE
//  Byte-stream loader directly upstream of the 4096x32 single-port on-chip RAM (s2 slave).
//  Packs an SOP/EOP-framed byte stream little-endian into 32-bit words and writes them from BASE_ADDR.
//  After EOP it reads every written word back and checks a checksum.
//  Status goes to the host CPU via done/verify_err/overflow.
// PARAMETERS
//  ADDR_W     12      RAM word-address width; DEPTH = 2**ADDR_W
//  BASE_ADDR  12'h000 first word address written on each SOP
// PORTS
//  clk             in   1   system clock; the only clock
//  reset           in   1   synchronous, active-high
//  in_data         in   8   stream byte
//  in_valid        in   1   byte valid
//  in_ready        out  1   byte accepted when in_valid & in_ready
//  in_sop          in   1   first byte of frame
//  in_eop          in   1   last byte of frame
//  mem_address     out  12  RAM word address
//  mem_byteenable  out  4   RAM byte lanes; lane i = writedata[8i+7:8i]
//  mem_chipselect  out  1   RAM select
//  mem_write       out  1   RAM write strobe (wren = chipselect & write)
//  mem_writedata   out  32  RAM write data
//  mem_clken       out  1   RAM clock enable; held 1
//  mem_readdata    in   32  RAM read data; address registered, q unregistered => valid cycle N+1
//  busy            out  1   frame in progress (FILL..VCMP)
//  done            out  1   1-cycle pulse when verify completes
//  verify_err      out  1   sticky: checksum mismatch; cleared on next SOP
//  overflow        out  1   sticky: bytes beyond DEPTH words dropped; cleared on next SOP
//  word_count      out  13  words written in last/current frame (0..4096)
// BEHAVIOUR
//  Reset: all outputs 0 except mem_clken=1; state IDLE; counters and checksums 0.
//  States: IDLE, FILL, WRITE, VRD, VCMP, DONE.
//  IDLE: in_ready=1. Byte with in_sop -> clear counts/sticky flags, addr=BASE_ADDR, lane 0 loaded, go FILL.
//   Non-SOP bytes in IDLE are accepted and discarded.
//  FILL: in_ready=1. Bytes fill lanes 0..3 in order; lane mask tracks loaded lanes.
//   4th byte or in_eop -> go WRITE. SOP inside FILL restarts the frame, discarding the partial word.
//   A byte with in_sop & in_eop is a 1-byte frame.
//  WRITE: in_ready=0. Exactly one cycle with chipselect=write=1,
//   address=addr, byteenable=lane mask (partial only on EOP word), writedata=packed word.
//   Unloaded lanes drive 0.
//   wsum += writedata & mask-expanded; word_count++; addr++.
//   Then: if EOP was seen -> VRD with raddr=BASE_ADDR; else -> FILL.
//  Write latency: 4th byte accepted cycle N -> write strobe cycle N+1; stream stalls one cycle per word.
//  Wrap: word_count==DEPTH with more bytes pending -> set overflow.
//   Further bytes accepted and dropped, no RAM write, until EOP. Then VRD. addr never wraps.
//  VRD: chipselect=1, write=0, address=raddr; next cycle VCMP.
//  VCMP: rsum += mem_readdata masked. The last word uses the final lane mask; all others use 4'hF.
//   raddr++. More words -> VRD, else DONE. Each read costs 2 cycles, no pipelining.
//  DONE: done=1 one cycle; verify_err=(rsum!=wsum); -> IDLE.
//  Frame of 0 words (not possible with SOP rule) is N/A.
//  Checksum: 32-bit modulo-2^32 sum.
//  Simultaneous: in_sop while busy in WRITE/VRD/VCMP is not accepted (in_ready=0); it is taken later in IDLE.
//  Reset mid-frame: abandon immediately. RAM contents are undefined for the frame; no done pulse.
//  mem_write is never asserted outside WRITE. mem_chipselect=0 in IDLE/FILL/DONE.
// STRUCTURE
//  Package embnew16k_loader_pkg:
//   state enum (3 bits)
//   MEM_W=32, BYTES=4 constants
//   function be2mask(4b)->32b lane mask
//  Sub-module embnew16k_byte_packer: byte->word packing, lane mask, last flag.
//  The FSM, counters and checksums stay in the top.
// TESTING
//  1. Reset, then frame 8 bytes 01..08 -> writes @0: 0x04030201 be=F, @1: 0x08070605 be=F.
//     Then 2 reads; done pulse, verify_err=0, word_count=2.
//  2. 5-byte frame AA BB CC DD EE -> second write @1 data 0x000000EE be=1.
//     Verify masks last word; verify_err=0.
//  3. RAM model corrupts word @1 -> done with verify_err=1; next SOP clears it.
//  4. 16388-byte frame -> 4096 writes, overflow=1, word_count=4096, no write after addr FFF.
//  5. SOP mid-FILL after 2 bytes -> partial discarded; restart at BASE_ADDR with the new byte in lane 0.
//  6. Reset asserted during VRD -> next cycle all outputs at reset values; no done pulse.

Source files
------------

// File: rtl/embnew16k_loader_pkg.sv
// embnew16k_loader_pkg: shared loader states, bus widths and lane-mask helper
package embnew16k_loader_pkg;
  typedef enum logic [2:0] {IDLE, FILL, WRITE, VRD, VCMP, DONE} state_t;
  localparam int MEM_W = 32;
  localparam int BYTES = 4;
  function automatic logic [MEM_W-1:0] be2mask(input logic [BYTES-1:0] be);
    logic [MEM_W-1:0] m;
    for (int i = 0; i < BYTES; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction
endpackage

// File: rtl/embnew16k_mem_loader_if.sv
// embnew16k_mem_loader_if: byte stream in and RAM bus out, loader is the master
interface embnew16k_mem_loader_if
  import embnew16k_loader_pkg::*;
#(
  parameter int ADDR_W = 12
);
  logic [7:0] in_data;
  logic in_valid, in_ready, in_sop, in_eop;
  logic [ADDR_W-1:0] mem_address;
  logic [BYTES-1:0] mem_byteenable;
  logic mem_chipselect, mem_write, mem_clken;
  logic [MEM_W-1:0] mem_writedata, mem_readdata;
  modport master(
    input in_data, in_valid, in_sop, in_eop, mem_readdata,
    output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
  modport slave(
    output in_data, in_valid, in_sop, in_eop, mem_readdata,
    input in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/embnew16k_byte_packer.sv
// embnew16k_byte_packer: packs bytes little-endian into a word with a loaded-lane mask
module embnew16k_byte_packer
  import embnew16k_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             sop,
  input  logic             eop,
  input  logic [7:0]       data,
  output logic [MEM_W-1:0] word,
  output logic [BYTES-1:0] mask,
  output logic             last,
  output logic             complete
);
  logic [1:0] idx;
  assign idx = mask[2] ? 2'd3 : mask[1] ? 2'd2 : {1'b0, mask[0]};
  assign complete = load & (eop | (!sop & idx == 2'd3));
  always_ff @(posedge clk)
    if (reset | flush) begin
      word <= '0;
      mask <= '0;
      last <= 1'b0;
    end else if (load) begin
      word <= sop ? MEM_W'(data) : word | (MEM_W'(data) << {idx, 3'b000});
      mask <= sop ? BYTES'(1) : mask | (BYTES'(1) << idx);
      last <= eop;
    end
endmodule

// File: rtl/embnew16k_mem_loader.sv
// embnew16k_mem_loader: writes a framed byte stream into RAM, then reads it back and checks a checksum
module embnew16k_mem_loader
  import embnew16k_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  embnew16k_mem_loader_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   verify_err,
  output logic                   overflow,
  output logic [ADDR_W:0]        word_count
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t state, nxt;
  logic accept, full, load, complete, last_rd, pk_last;
  logic [BYTES-1:0] pk_mask, last_mask;
  logic [MEM_W-1:0] pk_word, wsum, rsum, rsum_n;
  assign accept = bus.in_valid & bus.in_ready;
  assign full = word_count == DEPTH;
  assign load = accept & (bus.in_sop | (state == FILL & !full));
  assign last_rd = {1'b0, bus.mem_address - BASE_ADDR} + 1'b1 == word_count;
  assign rsum_n = rsum + (bus.mem_readdata & be2mask(last_rd ? last_mask : {BYTES{1'b1}}));
  assign bus.mem_clken = 1'b1;
  assign bus.mem_writedata = pk_word;
  assign bus.mem_byteenable = pk_mask;
  embnew16k_byte_packer u_pk (
    .clk, .reset, .flush(state == WRITE), .load, .sop(bus.in_sop), .eop(bus.in_eop),
    .data(bus.in_data), .word(pk_word), .mask(pk_mask), .last(pk_last), .complete
  );
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:  nxt = complete ? WRITE : accept & bus.in_sop ? FILL : IDLE;
      FILL:  nxt = complete ? WRITE : accept & !bus.in_sop & full & bus.in_eop ? VRD : FILL;
      WRITE: nxt = pk_last ? VRD : FILL;
      VRD:   nxt = VCMP;
      VCMP:  nxt = last_rd ? DONE : VRD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.in_ready <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      verify_err <= 1'b0;
      overflow <= 1'b0;
      word_count <= '0;
      wsum <= '0;
      rsum <= '0;
      last_mask <= '0;
    end else begin
      state <= nxt;
      bus.in_ready <= nxt == IDLE || nxt == FILL;
      bus.mem_chipselect <= nxt == WRITE || nxt == VRD;
      bus.mem_write <= nxt == WRITE;
      busy <= nxt inside {FILL, WRITE, VRD, VCMP};
      done <= nxt == DONE;
      if (accept & bus.in_sop) begin
        word_count <= '0;
        wsum <= '0;
        rsum <= '0;
        verify_err <= 1'b0;
        overflow <= 1'b0;
        bus.mem_address <= BASE_ADDR;
      end
      if (accept & !bus.in_sop & state == FILL & full) overflow <= 1'b1;
      if (state == WRITE) begin
        wsum <= wsum + (pk_word & be2mask(pk_mask));
        word_count <= word_count + 1'b1;
        last_mask <= pk_mask;
        bus.mem_address <= bus.mem_address + ADDR_W'(word_count != DEPTH - 1'b1);
      end
      if (state == VCMP) begin
        rsum <= rsum_n;
        if (last_rd) verify_err <= rsum_n != wsum;
      end
      if (nxt == VRD) bus.mem_address <= state == VCMP ? bus.mem_address + 1'b1 : BASE_ADDR;
    end
endmodule

// File: tb/tb_embnew16k_mem_loader.sv
// tb_embnew16k_mem_loader: random framed streams against a RAM model and a frame-level reference
module tb_embnew16k_mem_loader;
  localparam int ADDR_W = 12;
  localparam int DEPTH = 4096;
  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, done, verify_err, overflow;
  logic [12:0] word_count;
  logic [31:0] ram [DEPTH];
  logic [11:0] raddr_q;
  logic corrupt = 1'b0;
  wr_t wlog [$];
  int done_cnt = 0;
  int wr_rdy_bad = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] fr [$];
  logic [31:0] exp_w [DEPTH];
  logic [3:0] exp_be [DEPTH];
  embnew16k_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  embnew16k_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(12'h000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done(done),
    .verify_err(verify_err), .overflow(overflow), .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    raddr_q <= bus.mem_address;
    if (bus.mem_write && bus.in_ready) wr_rdy_bad <= wr_rdy_bad + 1;
    if (bus.mem_chipselect && bus.mem_write) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_byteenable[i]) ram[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
      wlog.push_back('{bus.mem_address, bus.mem_writedata, bus.mem_byteenable});
    end
  end
  assign bus.mem_readdata = ram[raddr_q] ^ ((corrupt && raddr_q == 12'd1) ? 32'h1 : 32'h0);
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] b, input logic s, input logic e);
    int n = 0;
    bus.in_data = b;
    bus.in_sop = s;
    bus.in_eop = e;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("ready_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_outputs"}, {busy, done, verify_err, overflow, word_count, bus.in_ready,
      bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable}, 0);
    check({tag, "_writedata"}, bus.mem_writedata, 0);
    check({tag, "_clken"}, bus.mem_clken, 1);
  endtask
  task automatic rand_frame(input int len);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
  endtask
  task automatic run_frame(input bit gaps, input bit corr);
    int n = fr.size();
    int nw = (n + 3) / 4 > DEPTH ? DEPTH : (n + 3) / 4;
    int wb = wlog.size();
    int t = 0;
    for (int k = 0; k < nw; k++) begin
      exp_w[k] = '0;
      exp_be[k] = '0;
    end
    for (int i = 0; i < n; i++)
      if (i / 4 < DEPTH) begin
        exp_w[i/4][8*(i%4) +: 8] = fr[i];
        exp_be[i/4][i%4] = 1'b1;
      end
    corrupt = corr;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) @(negedge clk);
      push(fr[i], i == 0, i == n - 1);
      if (i == 0) check("sop_clears_flags", {verify_err, overflow}, 0);
    end
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1);
    check("verify_err", verify_err, (corr && nw >= 2) ? 1 : 0);
    check("word_count", word_count, nw);
    check("overflow", overflow, n > 4 * DEPTH ? 1 : 0);
    check("n_writes", wlog.size() - wb, nw);
    for (int j = 0; j < nw && wb + j < wlog.size(); j++) begin
      check("wr_addr", wlog[wb+j].a, j);
      check("wr_data", wlog[wb+j].d, exp_w[j]);
      check("wr_be", wlog[wb+j].be, exp_be[j]);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", {busy, bus.in_ready}, 2'b01);
    corrupt = 1'b0;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, db;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    fr.delete();
    for (int i = 1; i <= 8; i++) fr.push_back(8'(i));
    run_frame(0, 0);
    check("t1_word1", {wlog[wlog.size()-1].a, wlog[wlog.size()-1].d, wlog[wlog.size()-1].be},
      {12'd1, 32'h08070605, 4'hF});
    fr = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_frame(0, 0);
    check("t2_word1", {wlog[wlog.size()-1].a, wlog[wlog.size()-1].d, wlog[wlog.size()-1].be},
      {12'd1, 32'h000000EE, 4'h1});
    rand_frame(20);
    run_frame(1, 1);
    rand_frame(13);
    run_frame(1, 0);
    push(8'h5A, 0, 0);
    push(8'hA5, 0, 1);
    rand_frame(1);
    run_frame(0, 0);
    push(8'h11, 1, 0);
    push(8'h22, 0, 0);
    rand_frame(9);
    run_frame(0, 0);
    repeat (8) begin
      rand_frame($urandom_range(1, 64));
      run_frame(1, $urandom_range(1) == 1);
    end
    rand_frame(4 * DEPTH + 4);
    run_frame(0, 0);
    check("ovf_last_addr", wlog[wlog.size()-1].a, 12'hFFF);
    check("ready_low_in_write", wr_rdy_bad, 0);
    rand_frame(12);
    for (int i = 0; i < 12; i++) push(fr[i], i == 0, i == 11);
    t = 0;
    while (!(bus.mem_chipselect && !bus.mem_write) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("vrd_reached", {bus.mem_chipselect, bus.mem_write}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid_vrd_reset");
    reset = 1'b0;
    db = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt - db, 0);
    rand_frame(7);
    run_frame(1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
